// File: rtl/fsm_vector_driver_pkg.sv
// Shared definitions for the FSM vector driver: control states, vector field
// layout and the state constants of the downstream 5-state FSM.
package fsm_vector_driver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FSMRST,
    DRIVE,
    CHECK,
    FINISH
  } state_t;

  // Packed vector layout: {in[12:10], cs[9:7], ns[6:4], exp_out[3:0]}
  localparam int unsigned VEC_W   = 13;
  localparam int unsigned IN_LSB  = 10;
  localparam int unsigned IN_W    = 3;
  localparam int unsigned CS_LSB  = 7;
  localparam int unsigned CS_W    = 3;
  localparam int unsigned NS_LSB  = 4;
  localparam int unsigned NS_W    = 3;
  localparam int unsigned EXP_LSB = 0;
  localparam int unsigned EXP_W   = 4;

  localparam logic [2:0] ZERO  = 3'd0;
  localparam logic [2:0] ONE   = 3'd1;
  localparam logic [2:0] TWO   = 3'd2;
  localparam logic [2:0] THREE = 3'd3;
  localparam logic [2:0] FOUR  = 3'd4;

endpackage

// File: rtl/fsm_vector_driver_vec_mem.sv
// Test vector storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module vec_mem
  import fsm_vector_driver_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [VEC_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [VEC_W-1:0] rdata
);

  logic [VEC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_vector_driver.sv
// Drives stored stimulus vectors into a downstream 5-state FSM, two cycles
// per vector, and scores its returned output against the expected value.
module fsm_vector_driver
  import fsm_vector_driver_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  input  logic [VEC_W-1:0] ld_data,
  output logic             ld_ready,
  input  logic             start,
  input  logic             clear,
  output logic             fsm_reset,
  output logic [2:0]       fsm_in,
  output logic [2:0]       fsm_cs,
  output logic [2:0]       fsm_ns,
  output logic [3:0]       fsm_exp_out,
  input  logic [3:0]       fsm_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      err_count,
  output logic [AW-1:0]    first_err_idx
);

  state_t           state, state_nxt;
  logic [AW:0]      vec_count;
  logic [AW-1:0]    idx;
  logic [VEC_W-1:0] rd_vec;
  logic [AW:0]      err_nxt;
  logic             ld_fire;
  logic             mismatch;
  logic [AW:0]      run_count;
  logic [AW:0]      idx_inc;

  assign ld_ready  = (state == IDLE) && (vec_count < (AW+1)'(DEPTH));
  assign ld_fire   = ld_valid && ld_ready && !clear;
  assign run_count = vec_count + (AW+1)'(ld_fire);
  assign idx_inc   = (AW+1)'(idx) + (AW+1)'(1);
  assign mismatch  = (state == CHECK) && (fsm_out != fsm_exp_out);
  assign busy      = (state == FSMRST) || (state == DRIVE) || (state == CHECK);
  assign done      = (state == FINISH);

  vec_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_vec_mem (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (vec_count[AW-1:0]),
    .wdata (ld_data),
    .raddr (idx),
    .rdata (rd_vec)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_count;
    case (state)
      IDLE: begin
        if (start) begin
          err_nxt = '0;
          // a same-cycle clear empties the run; a same-cycle load joins it
          if (clear || run_count == '0) state_nxt = FINISH;
          else                          state_nxt = FSMRST;
        end
      end
      FSMRST: state_nxt = DRIVE;
      DRIVE:  state_nxt = CHECK;
      CHECK: begin
        if (mismatch && err_count != (AW+1)'(DEPTH)) err_nxt = err_count + (AW+1)'(1);
        if (idx_inc < vec_count) state_nxt = DRIVE;
        else                     state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vec_count     <= '0;
      idx           <= '0;
      fsm_reset     <= 1'b1;
      fsm_in        <= '0;
      fsm_cs        <= '0;
      fsm_ns        <= '0;
      fsm_exp_out   <= '0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      fsm_reset <= (state_nxt == FSMRST);
      err_count <= err_nxt;
      if (state == IDLE) begin
        if (clear)        vec_count <= '0;
        else if (ld_fire) vec_count <= vec_count + (AW+1)'(1);
        if (start) begin
          idx           <= '0;
          first_err_idx <= '0;
          pass          <= 1'b0;
        end
      end
      if (state == DRIVE) begin
        fsm_in      <= rd_vec[IN_LSB  +: IN_W];
        fsm_cs      <= rd_vec[CS_LSB  +: CS_W];
        fsm_ns      <= rd_vec[NS_LSB  +: NS_W];
        fsm_exp_out <= rd_vec[EXP_LSB +: EXP_W];
      end
      if (state == CHECK) begin
        if (mismatch && err_count == '0) first_err_idx <= idx;
        idx <= idx + AW'(1);
      end
      // pass must already be valid in the done cycle, so use the final count
      if (state_nxt == FINISH) pass <= (err_nxt == '0);
    end
  end

endmodule
